// File: rtl/cache_memory_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM states and master identifiers.
package cache_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        MST_ICACHE = 1'b0,
        MST_DCACHE = 1'b1
    } master_t;

    function automatic master_t other_master(input master_t m);
        return (m == MST_ICACHE) ? MST_DCACHE : MST_ICACHE;
    endfunction

endpackage

// File: rtl/cache_memory_arbiter_rr_burst_picker.sv
// Combinational winner select: burst-limited round-robin between I-cache and D-cache.
module rr_burst_picker
    import cache_memory_arbiter_pkg::*;
#(
    parameter int unsigned BURST_BEATS = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic             icache_req,
    input  logic             dcache_req,
    input  master_t          last_grant,
    input  logic [CNT_W-1:0] beat_cnt,
    output master_t          winner_c
);

    // beat_cnt==0 only before the first grant after reset: tie goes to D-cache
    always_comb begin
        winner_c = MST_DCACHE;
        if (icache_req && dcache_req) begin
            if (beat_cnt == '0) begin
                winner_c = MST_DCACHE;
            end else if (beat_cnt < CNT_W'(BURST_BEATS)) begin
                winner_c = last_grant;
            end else begin
                winner_c = other_master(last_grant);
            end
        end else if (icache_req) begin
            winner_c = MST_ICACHE;
        end
    end

endmodule

// File: rtl/cache_memory_arbiter.sv
// Arbitrates I-cache and D-cache requests onto a single main-memory port,
// one transaction outstanding at a time.
module cache_memory_arbiter
    import cache_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BURST_BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   icache_mem_addr,
    input  logic                    icache_mem_req,
    output logic [DATA_WIDTH-1:0]   icache_mem_rdata,
    output logic                    icache_mem_ready,
    input  logic [ADDR_WIDTH-1:0]   dcache_mem_addr,
    input  logic [DATA_WIDTH-1:0]   dcache_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] dcache_mem_be,
    input  logic                    dcache_mem_we,
    input  logic                    dcache_mem_req,
    output logic [DATA_WIDTH-1:0]   dcache_mem_rdata,
    output logic                    dcache_mem_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    mem_we,
    output logic                    mem_req,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    localparam int unsigned CNT_W = $clog2(BURST_BEATS + 1);

    state_t           state_q;
    state_t           state_d;
    logic             grant_c;
    logic             capture_c;
    master_t          winner_c;
    master_t          last_grant_q;
    logic [CNT_W-1:0] beat_cnt_q;

    rr_burst_picker #(
        .BURST_BEATS (BURST_BEATS),
        .CNT_W       (CNT_W)
    ) u_picker (
        .icache_req (icache_mem_req),
        .dcache_req (dcache_mem_req),
        .last_grant (last_grant_q),
        .beat_cnt   (beat_cnt_q),
        .winner_c   (winner_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus grant/capture strobes for the datapath
    always_comb begin
        state_d   = state_q;
        grant_c   = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (icache_mem_req || dcache_mem_req) begin
                    grant_c = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    capture_c = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, burst bookkeeping and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_be           <= '0;
            mem_we           <= 1'b0;
            mem_req          <= 1'b0;
            icache_mem_rdata <= '0;
            icache_mem_ready <= 1'b0;
            dcache_mem_rdata <= '0;
            dcache_mem_ready <= 1'b0;
            last_grant_q     <= MST_ICACHE;
            beat_cnt_q       <= '0;
        end else begin
            icache_mem_ready <= 1'b0;
            dcache_mem_ready <= 1'b0;
            if (grant_c) begin
                mem_req      <= 1'b1;
                last_grant_q <= winner_c;
                if (winner_c == MST_DCACHE) begin
                    mem_addr  <= dcache_mem_addr;
                    mem_wdata <= dcache_mem_wdata;
                    mem_be    <= dcache_mem_be;
                    mem_we    <= dcache_mem_we;
                end else begin
                    mem_addr  <= icache_mem_addr;
                    mem_wdata <= '0;
                    mem_be    <= '1;
                    mem_we    <= 1'b0;
                end
                if (winner_c != last_grant_q) begin
                    beat_cnt_q <= CNT_W'(1);
                end else if (beat_cnt_q < CNT_W'(BURST_BEATS)) begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
            end
            if (capture_c) begin
                mem_req <= 1'b0;
                if (last_grant_q == MST_DCACHE) begin
                    dcache_mem_rdata <= mem_rdata;
                    dcache_mem_ready <= 1'b1;
                end else begin
                    icache_mem_rdata <= mem_rdata;
                    icache_mem_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Scoreboard bench for cache_memory_arbiter: cache drivers, memory model and
// expected-grant / expected-response queues.
module tb_cache_memory_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] icache_mem_addr;
    logic        icache_mem_req;
    logic [31:0] icache_mem_rdata;
    logic        icache_mem_ready;
    logic [31:0] dcache_mem_addr;
    logic [31:0] dcache_mem_wdata;
    logic [3:0]  dcache_mem_be;
    logic        dcache_mem_we;
    logic        dcache_mem_req;
    logic [31:0] dcache_mem_rdata;
    logic        dcache_mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    cache_memory_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .BURST_BEATS (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_mem_addr  (icache_mem_addr),
        .icache_mem_req   (icache_mem_req),
        .icache_mem_rdata (icache_mem_rdata),
        .icache_mem_ready (icache_mem_ready),
        .dcache_mem_addr  (dcache_mem_addr),
        .dcache_mem_wdata (dcache_mem_wdata),
        .dcache_mem_be    (dcache_mem_be),
        .dcache_mem_we    (dcache_mem_we),
        .dcache_mem_req   (dcache_mem_req),
        .dcache_mem_rdata (dcache_mem_rdata),
        .dcache_mem_ready (dcache_mem_ready),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_we           (mem_we),
        .mem_req          (mem_req),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    txn_t        exp_grant_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] i_pend[$];
    txn_t        d_pend[$];

    int   wait_cfg   = 0;
    logic mem_busy   = 1'b0;
    int   mem_cnt    = 0;
    logic idle_pulse = 1'b0;
    txn_t cur_txn;
    txn_t exp_txn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BFEF;
    endfunction

    task automatic push_i(input logic [31:0] a);
        txn_t t;
        t = '{addr: a, wdata: 32'h0, be: 4'hF, we: 1'b0};
        i_pend.push_back(a);
        exp_i_q.push_back(rd_of(a));
        exp_grant_q.push_back(t);
    endtask

    task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic we);
        txn_t t;
        t = '{addr: a, wdata: wd, be: be, we: we};
        d_pend.push_back(t);
        exp_d_q.push_back(rd_of(a));
    endtask

    task automatic expect_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                            input logic we);
        txn_t t;
        t = '{addr: a, wdata: wd, be: be, we: we};
        exp_grant_q.push_back(t);
    endtask

    task automatic check_outputs_idle(input string tag);
        check_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_i_ready"}, 32'(icache_mem_ready), 32'd0);
        check_eq({tag, "_d_ready"}, 32'(dcache_mem_ready), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_grant_q.delete();
        exp_i_q.delete();
        exp_d_q.delete();
        i_pend.delete();
        d_pend.delete();
        icache_mem_req = 1'b0;
        dcache_mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_outputs_idle("rst");
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_be", 32'(mem_be), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we), 32'h0);
        check_eq("rst_i_rdata", icache_mem_rdata, 32'h0);
        check_eq("rst_d_rdata", dcache_mem_rdata, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        int pending;
        k = 0;
        pending = 1;
        while (pending != 0 && k < 2000) begin
            @(posedge clk);
            #2;
            k++;
            pending = i_pend.size() + d_pend.size() + exp_grant_q.size()
                    + exp_i_q.size() + exp_d_q.size() + int'(mem_req);
        end
        check_eq({tag, "_drain"}, 32'(pending), 32'd0);
        @(posedge clk);
        #2;
    endtask

    // Cache drivers, response scoreboard and main-memory model, all at negedge
    initial begin
        forever begin
            @(negedge clk);
            if (icache_mem_ready) begin
                check_eq("i_ready_expected", 32'(exp_i_q.size() != 0), 32'd1);
                if (exp_i_q.size() != 0) check_eq("i_rdata", icache_mem_rdata, exp_i_q.pop_front());
                if (i_pend.size() != 0) void'(i_pend.pop_front());
            end
            if (dcache_mem_ready) begin
                check_eq("d_ready_expected", 32'(exp_d_q.size() != 0), 32'd1);
                if (exp_d_q.size() != 0) check_eq("d_rdata", dcache_mem_rdata, exp_d_q.pop_front());
                if (d_pend.size() != 0) void'(d_pend.pop_front());
            end
            if (icache_mem_ready || dcache_mem_ready)
                check_eq("ready_overlap", 32'(icache_mem_ready & dcache_mem_ready), 32'd0);

            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_busy  = 1'b0;
                check_eq("mem_req_drop", 32'(mem_req), 32'd0);
            end else if (mem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = wait_cfg;
                    cur_txn  = '{addr: mem_addr, wdata: mem_wdata, be: mem_be, we: mem_we};
                    check_eq("grant_expected", 32'(exp_grant_q.size() != 0), 32'd1);
                    if (exp_grant_q.size() != 0) begin
                        exp_txn = exp_grant_q.pop_front();
                        check_eq("grant_addr", cur_txn.addr, exp_txn.addr);
                        check_eq("grant_we", 32'(cur_txn.we), 32'(exp_txn.we));
                        check_eq("grant_be", 32'(cur_txn.be), 32'(exp_txn.be));
                        if (exp_txn.we) check_eq("grant_wdata", cur_txn.wdata, exp_txn.wdata);
                    end
                end
                if (mem_cnt == 0) begin
                    check_eq("stable_addr", mem_addr, cur_txn.addr);
                    check_eq("stable_wdata", mem_wdata, cur_txn.wdata);
                    check_eq("stable_be_we", {27'h0, mem_be, mem_we}, {27'h0, cur_txn.be, cur_txn.we});
                    mem_ready = 1'b1;
                    mem_rdata = rd_of(mem_addr);
                end else begin
                    mem_cnt--;
                end
            end else begin
                mem_busy = 1'b0;
                if (idle_pulse) begin
                    mem_ready  = 1'b1;
                    mem_rdata  = 32'hBAD0_BAD0;
                    idle_pulse = 1'b0;
                end
            end

            icache_mem_req = (i_pend.size() != 0);
            if (i_pend.size() != 0) icache_mem_addr = i_pend[0];
            dcache_mem_req = (d_pend.size() != 0);
            if (d_pend.size() != 0) begin
                dcache_mem_addr  = d_pend[0].addr;
                dcache_mem_wdata = d_pend[0].wdata;
                dcache_mem_be    = d_pend[0].be;
                dcache_mem_we    = d_pend[0].we;
            end
        end
    end

    initial begin
        int k;
        rst_n            = 1'b0;
        icache_mem_addr  = '0;
        icache_mem_req   = 1'b0;
        dcache_mem_addr  = '0;
        dcache_mem_wdata = '0;
        dcache_mem_be    = '0;
        dcache_mem_we    = 1'b0;
        dcache_mem_req   = 1'b0;
        mem_rdata        = '0;
        mem_ready        = 1'b0;
        do_reset();

        // I-cache read with two memory wait cycles
        wait_cfg = 2;
        push_i(32'h0000_0100);
        drain("t1");

        // Simultaneous first requests after reset: D-cache wins
        do_reset();
        wait_cfg = 1;
        expect_d(32'h0000_0200, 32'h0, 4'hF, 1'b0);
        push_d(32'h0000_0200, 32'h0, 4'hF, 1'b0);
        push_i(32'h0000_0180);
        drain("t2");

        // D-cache stream of 8 with I-cache pending: 4 D, then I, then 4 D
        do_reset();
        wait_cfg = 0;
        for (int n = 0; n < 4; n++) begin
            expect_d(32'h0000_3000 + 32'(n * 4), 32'h0, 4'hF, 1'b0);
            push_d(32'h0000_3000 + 32'(n * 4), 32'h0, 4'hF, 1'b0);
        end
        push_i(32'h0000_1000);
        for (int n = 4; n < 8; n++) begin
            expect_d(32'h0000_3000 + 32'(n * 4), 32'h0, 4'hF, 1'b0);
            push_d(32'h0000_3000 + 32'(n * 4), 32'h0, 4'hF, 1'b0);
        end
        drain("t3");

        // D-cache partial write
        wait_cfg = 2;
        expect_d(32'h0000_2004, 32'h1234_5678, 4'b0011, 1'b1);
        push_d(32'h0000_2004, 32'h1234_5678, 4'b0011, 1'b1);
        drain("t4");

        // Reset asserted while a transaction is in ISSUE
        wait_cfg = 3;
        expect_d(32'h0000_0500, 32'h0, 4'hF, 1'b0);
        push_d(32'h0000_0500, 32'h0, 4'hF, 1'b0);
        k = 0;
        while (!mem_req && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        check_eq("t5_mem_req_seen", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_idle("t5_async");
        do_reset();
        wait_cfg = 1;
        expect_d(32'h0000_0600, 32'h0, 4'hF, 1'b0);
        push_d(32'h0000_0600, 32'h0, 4'hF, 1'b0);
        push_i(32'h0000_0700);
        drain("t5");

        // Stray mem_ready while idle is ignored
        idle_pulse = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #2;
            check_outputs_idle("t6_idle");
        end
        wait_cfg = 0;
        push_i(32'h0000_0840);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
